// File: rtl/pipeline_flow_types.sv
// Flow structures and encodings shared by the EX/MEM and MEM/WB pipeline stages.
package pipeline_flow_types;

  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} mem_width_e;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} mem_state_e;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    mem_width_e MemWidth;
    logic       MemUnsigned;
  } mem_ctrl_t;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] WbSel;
  } wb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [31:0] pc_incr;
    logic [31:0] pc_offset;
    logic [31:0] immediate;
    logic [4:0]  rd_addr;
    mem_ctrl_t   mem_ctrl;
    wb_ctrl_t    wb_ctrl;
  } ex_mem_flow_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc_incr;
    logic [31:0] pc_offset;
    logic [31:0] immediate;
    logic [4:0]  rd_addr;
    wb_ctrl_t    wb_ctrl;
    logic        misaligned;
  } mem_wb_flow_t;

  // Forwarding and hazard views driven by the MEM stage.
  typedef struct packed {
    logic [31:0] mem;
  } fwd_data_t;

  typedef struct packed {
    logic [4:0] rd_addr;
  } fwd_stage_t;

  typedef struct packed {
    fwd_data_t  data;
    fwd_stage_t mem;
  } fwd_mem_t;

  typedef struct packed {
    logic stall;
  } hazard_stage_t;

  typedef struct packed {
    hazard_stage_t mem;
  } hazard_mem_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for stores, load extract/extend, misalign flag.
// MEM_MISALIGN_CHECK_EN enables the misalignment flag; otherwise it is tied low.
module load_store_align
  import pipeline_flow_types::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_width_e  width,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_byte = load_word[7:0];
      2'd1:    lane_byte = load_word[15:8];
      2'd2:    lane_byte = load_word[23:16];
      default: lane_byte = load_word[31:24];
    endcase
    // Half accesses only look at addr_lo[1]; bit 0 is ignored or flagged.
    lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    wdata     = store_data;
    wstrb     = 4'b1111;
    load_data = load_word;
    case (width)
      BYTE: begin
        wdata     = {4{store_data[7:0]}};
        wstrb     = 4'b0001 << addr_lo;
        load_data = {{24{~is_unsigned & lane_byte[7]}}, lane_byte};
      end
      HALF: begin
        wdata     = {2{store_data[15:0]}};
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = {{16{~is_unsigned & lane_half[15]}}, lane_half};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = ((width == HALF) && addr_lo[0]) ||
                      ((width == WORD) && (addr_lo != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack data port, stall generation, one-shot store FSM.
// Optional MEM_MISALIGN_CHECK_EN blocks misaligned accesses and flags them downstream.
module mem_stage
  import pipeline_flow_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  ex_mem_flow_t inflow,
  input  logic         advance,
  output mem_wb_flow_t outflow,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [31:0]  dmem_addr,
  output logic [31:0]  dmem_wdata,
  output logic [3:0]   dmem_wstrb,
  input  logic         dmem_ack,
  input  logic [31:0]  dmem_rdata,
  output fwd_mem_t     fd,
  output hazard_mem_t  hd
);

  mem_state_e  state;
  logic [31:0] rdata_q;

  logic        op;
  logic        misaligned;
  logic        active;
  logic        pending;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] load_word;
  logic [31:0] load_data;

  assign op        = inflow.mem_ctrl.MemRead | inflow.mem_ctrl.MemWrite;
  assign active    = op & ~misaligned;
  // HOLD means the access already completed; never reissue it.
  assign pending   = active & (state != HOLD) & ~rst;
  assign load_word = (state == HOLD) ? rdata_q : dmem_rdata;

  load_store_align u_align (
    .addr_lo     (inflow.alu_result[1:0]),
    .width       (inflow.mem_ctrl.MemWidth),
    .is_unsigned (inflow.mem_ctrl.MemUnsigned),
    .store_data  (inflow.rs2_data),
    .load_word   (load_word),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  assign dmem_req   = pending;
  assign dmem_we    = inflow.mem_ctrl.MemWrite;
  assign dmem_addr  = {inflow.alu_result[31:2], 2'b00};
  assign dmem_wdata = wdata;
  assign dmem_wstrb = inflow.mem_ctrl.MemWrite ? wstrb : 4'b0000;

  always_comb begin
    hd.mem.stall   = pending & ~dmem_ack;
    fd.data.mem    = inflow.alu_result;
    fd.mem.rd_addr = inflow.rd_addr;
  end

  always_comb begin
    outflow.alu_result = inflow.alu_result;
    outflow.pc_incr    = inflow.pc_incr;
    outflow.pc_offset  = inflow.pc_offset;
    outflow.immediate  = inflow.immediate;
    outflow.rd_addr    = inflow.rd_addr;
    outflow.wb_ctrl    = inflow.wb_ctrl;
    outflow.misaligned = op & misaligned;
    outflow.mem_data   = (inflow.mem_ctrl.MemRead & ~misaligned) ? load_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE, WAIT: begin
          if (!active) begin
            state <= IDLE;
          end else if (dmem_ack) begin
            if (advance) begin
              state <= IDLE;
            end else begin
              state   <= HOLD;
              rdata_q <= dmem_rdata;
            end
          end else begin
            state <= WAIT;
          end
        end
        HOLD: begin
          if (advance) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against an arithmetic reference model.
module tb_mem_stage;
  import pipeline_flow_types::*;

  logic         clk = 1'b0;
  logic         rst;
  ex_mem_flow_t inflow;
  logic         advance;
  mem_wb_flow_t outflow;
  logic         dmem_req, dmem_we;
  logic [31:0]  dmem_addr, dmem_wdata;
  logic [3:0]   dmem_wstrb;
  logic         dmem_ack;
  logic [31:0]  dmem_rdata;
  fwd_mem_t     fd;
  hazard_mem_t  hd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .inflow     (inflow),
    .advance    (advance),
    .outflow    (outflow),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .fd         (fd),
    .hd         (hd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int size_of(mem_width_e w);
    return (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
  endfunction

  function automatic int lane_off(logic [31:0] addr, int sz);
    return (sz == 4) ? 0 : (int'(addr % 4) / sz) * sz;
  endfunction

  function automatic bit model_mis(bit op, logic [31:0] addr, int sz);
`ifdef MEM_MISALIGN_CHECK_EN
    return op && ((addr % sz) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_wdata(logic [31:0] rs2, int sz);
    if (sz == 1) return (rs2 & 32'hFF) * 32'h01010101;
    if (sz == 2) return (rs2 & 32'hFFFF) * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [31:0] model_wstrb(logic [31:0] addr, int sz);
    int mask = (1 << sz) - 1;
    return 32'(mask << lane_off(addr, sz));
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] word, logic [31:0] addr, int sz, bit uns);
    longint v = longint'(word) >> (8 * lane_off(addr, sz));
    if (sz < 4) begin
      v = v % (longint'(1) << (8 * sz));
      if (!uns && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    end
    return v[31:0];
  endfunction

  task automatic set_inflow(input bit rd, input bit wr, input mem_width_e w, input bit uns,
                            input logic [31:0] addr, input logic [31:0] rs2);
    inflow.alu_result           = addr;
    inflow.rs2_data             = rs2;
    inflow.pc_incr              = $urandom;
    inflow.pc_offset            = $urandom;
    inflow.immediate            = $urandom;
    inflow.rd_addr              = 5'($urandom);
    inflow.mem_ctrl.MemRead     = rd;
    inflow.mem_ctrl.MemWrite    = wr;
    inflow.mem_ctrl.MemWidth    = w;
    inflow.mem_ctrl.MemUnsigned = uns;
    inflow.wb_ctrl              = 3'($urandom);
  endtask

  // One instruction through MEM: ack arrives after lat cycles, advance held low for hold more.
  task automatic run_txn(input bit rd, input bit wr, input mem_width_e w, input bit uns,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                         input int lat, input int hold);
    int          sz;
    bit          mis, act;
    logic [31:0] exp_data;
    @(negedge clk);
    set_inflow(rd, wr, w, uns, addr, rs2);
    sz       = size_of(w);
    mis      = model_mis(rd | wr, addr, sz);
    act      = (rd | wr) && !mis;
    exp_data = (rd && !mis) ? model_load(rdata, addr, sz, uns) : 32'h0;
    if (!act) begin
      dmem_ack = 1'b0; advance = 1'b1; dmem_rdata = $urandom;
      #1;
      check("noop_req", dmem_req, 0);
      check("noop_stall", hd.mem.stall, 0);
      check("misaligned", outflow.misaligned, mis);
      check("noop_data", outflow.mem_data, exp_data);
      check("fwd_data", fd.data.mem, addr);
    end else begin
      for (int k = 0; k <= lat + hold; k++) begin
        if (k > 0) @(negedge clk);
        dmem_ack   = (k == lat);
        advance    = (k == lat + hold);
        dmem_rdata = (k == lat) ? rdata : $urandom;
        #1;
        check("req", dmem_req, (k <= lat));
        check("stall", hd.mem.stall, (k < lat));
        if (k <= lat) begin
          check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
          check("we", dmem_we, wr);
          check("wstrb", dmem_wstrb, wr ? model_wstrb(addr, sz) : 32'h0);
          if (wr) check("wdata", dmem_wdata, model_wdata(rs2, sz));
        end
        if (!rd || k >= lat) check("mem_data", outflow.mem_data, exp_data);
        if (k == 0) begin
          check("misaligned", outflow.misaligned, 0);
          check("fwd_rd", fd.mem.rd_addr, inflow.rd_addr);
          check("pc_incr", outflow.pc_incr, inflow.pc_incr);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; advance = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_inflow(1'b1, 1'b0, WORD, 1'b0, 32'h100, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_stall", hd.mem.stall, 0);
    rst = 1'b0;

    // Directed cases.
    run_txn(1'b0, 1'b1, BYTE, 1'b0, 32'h1002, 32'h000000AB, 32'h0, 0, 0);
    run_txn(1'b1, 1'b0, HALF, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 3, 0);
    run_txn(1'b1, 1'b0, BYTE, 1'b1, 32'h2001, 32'h0, 32'h0000_F000, 1, 0);
    run_txn(1'b0, 1'b1, WORD, 1'b0, 32'h1004, 32'hCAFE_F00D, 32'h0, 0, 2);
    run_txn(1'b1, 1'b0, WORD, 1'b0, 32'h3001, 32'h0, 32'h1357_9BDF, 0, 0);
    run_txn(1'b1, 1'b0, HALF, 1'b1, 32'h3003, 32'h0, 32'hA5A5_5A5A, 2, 1);

    // Reset while a request is waiting; HOLD first so rdata_q is non-zero.
    run_txn(1'b1, 1'b0, WORD, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, 1);
    @(negedge clk);
    set_inflow(1'b1, 1'b0, WORD, 1'b0, 32'h50, 32'h0);
    dmem_ack = 1'b0; advance = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait_req", dmem_req, 0);
    check("rst_wait_stall", hd.mem.stall, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_rdata_q", dut.rdata_q, 0);
    check("post_rst_req", dmem_req, 1);
    dmem_ack = 1'b1; advance = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      int kind = $urandom_range(0, 2);
      run_txn(kind == 1, kind == 2, mem_width_e'($urandom_range(0, 2)), 1'($urandom),
              $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
